// File: rtl/wb_mac_pkg.sv
// wb_mac_pkg: register offsets, CTRL/STATUS bit positions, sequencer states and lowest-set-bit helper
package wb_mac_pkg;
  localparam logic [4:0] OFF_A = 5'h00, OFF_B = 5'h04, OFF_PL = 5'h08, OFF_PH = 5'h0C, OFF_CTRL = 5'h10;
  localparam logic [31:0] ADR_CMD = 32'h100, ADR_STATUS = 32'h104, ADR_IO = 32'h108;
  localparam int CTRL_SIGNED = 0, CTRL_SAT = 1, CTRL_SUB = 2;
  localparam int ST_BUSY = 0, ST_DROP = 1, ST_OVF = 8;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC} seq_state_t;
  function automatic logic [2:0] first_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/wb_mac_array_dac.sv
// sd_dac_channel: first-order sigma-delta DAC; din accumulated each cycle, dout is the registered carry-out
module sd_dac_channel #(
  parameter int DAC_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [DAC_W-1:0] din,
  output logic             dout
);
  logic [DAC_W-1:0] acc;
  logic [DAC_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, din};
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      acc <= '0;
      dout <= 1'b0;
    end else begin
      acc <= sum[DAC_W-1:0];
      dout <= sum[DAC_W];
    end
  end
endmodule

// File: rtl/wb_mac_array.sv
// wb_mac_array: Wishbone MAC array (shared multiplier, per-channel A/B/P/CTRL, CMD/STATUS) plus sigma-delta DACs on io_out from la_data_in
module wb_mac_array
  import wb_mac_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int A_W = 25,
  parameter int B_W = 18,
  parameter int P_W = 48,
  parameter int DAC_CH = 8,
  parameter int DAC_W = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wb_CYC,
  input  logic         wb_STB,
  input  logic         wb_WE,
  output logic         wb_ACK,
  input  logic [31:0]  wb_ADR,
  input  logic [31:0]  wb_DAT_MOSI,
  output logic [31:0]  wb_DAT_MISO,
  input  logic         wb_SEL,
  input  logic [127:0] la_data_in,
  input  logic [37:0]  io_in,
  output logic [37:0]  io_out,
  output logic [37:0]  io_oeb
);
  localparam int M = A_W + B_W;
  logic [A_W-1:0] a [CHANNELS];
  logic [B_W-1:0] b [CHANNELS];
  logic [P_W-1:0] p [CHANNELS];
  logic [2:0] ctrl [CHANNELS];
  logic [CHANNELS-1:0] ovf;
  logic wr_drop;
  seq_state_t state, nxt;
  logic [2:0] ch, ch_nxt;
  logic [7:0] mask, mask_nxt, rem, cmd_mask;
  logic [M-1:0] prod, prod_u;
  logic signed [M-1:0] prod_s;
  logic [A_W-1:0] mul_a;
  logic [B_W-1:0] mul_b;
  logic [P_W-1:0] p_cur, p_new, sat_val;
  logic [P_W+1:0] pe, me, sum;
  logic sgn, sat, sub, ov;
  logic [4:0] off;
  logic wr, busy, ch_space, reg_hit, ch_wr, cmd_wr, st_wr, drop, start;
  logic [31:0] status;
  logic unused_ok;
  assign unused_ok = ^{wb_SEL, io_in[37:32], la_data_in};
  assign off = wb_ADR[4:0];
  assign wr = wb_CYC & wb_STB & wb_WE & wb_ACK;
  assign busy = state != S_IDLE;
  assign ch_space = wb_ADR[31:8] == 24'd0 && int'(wb_ADR[7:5]) < CHANNELS;
  assign reg_hit = off == OFF_A || off == OFF_B || off == OFF_PL || off == OFF_PH || off == OFF_CTRL;
  assign ch_wr = wr & ch_space & reg_hit;
  assign cmd_wr = wr && wb_ADR == ADR_CMD;
  assign st_wr = wr && wb_ADR == ADR_STATUS;
  assign drop = busy & (cmd_wr | ch_wr);
  assign cmd_mask = 8'(wb_DAT_MOSI[CHANNELS-1:0]);
  assign start = cmd_wr & ~busy & |cmd_mask;
  assign status = {16'd0, 8'(ovf), 6'd0, wr_drop, busy};
  always_comb begin
    nxt = state;
    ch_nxt = ch;
    mask_nxt = mask;
    rem = mask & ~(8'd1 << ch);
    case (state)
      S_IDLE: if (start) begin
        nxt = S_MUL;
        mask_nxt = cmd_mask;
        ch_nxt = first_set(cmd_mask);
      end
      S_MUL: nxt = S_ACC;
      S_ACC: begin
        nxt = |rem ? S_MUL : S_IDLE;
        mask_nxt = rem;
        ch_nxt = first_set(rem);
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    p_cur = '0;
    sgn = 1'b0;
    sat = 1'b0;
    sub = 1'b0;
    for (int c = 0; c < CHANNELS; c++) if (ch == 3'(c)) begin
      mul_a = a[c];
      mul_b = b[c];
      p_cur = p[c];
      sgn = ctrl[c][CTRL_SIGNED];
      sat = ctrl[c][CTRL_SAT];
      sub = ctrl[c][CTRL_SUB];
    end
  end
  assign prod_s = $signed({{B_W{mul_a[A_W-1]}}, mul_a}) * $signed({{A_W{mul_b[B_W-1]}}, mul_b});
  assign prod_u = {{B_W{1'b0}}, mul_a} * {{A_W{1'b0}}, mul_b};
  // Two guard bits hold any P +/- product exactly, so range checks are just top-bit comparisons.
  assign pe = sgn ? {{2{p_cur[P_W-1]}}, p_cur} : {2'b00, p_cur};
  assign me = sgn ? {{(P_W+2-M){prod[M-1]}}, prod} : {{(P_W+2-M){1'b0}}, prod};
  assign sum = sub ? pe - me : pe + me;
  assign ov = sgn ? !(sum[P_W+1:P_W-1] == 3'b000 || sum[P_W+1:P_W-1] == 3'b111) : |sum[P_W+1:P_W];
  assign sat_val = sgn ? (sum[P_W+1] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}})
                       : (sum[P_W+1] ? {P_W{1'b0}} : {P_W{1'b1}});
  assign p_new = (ov & sat) ? sat_val : sum[P_W-1:0];
  always_comb begin
    wb_DAT_MISO = wb_ADR == ADR_STATUS ? status : wb_ADR == ADR_IO ? io_in[31:0] : 32'd0;
    for (int c = 0; c < CHANNELS; c++) if (ch_space && wb_ADR[7:5] == 3'(c))
      wb_DAT_MISO = off == OFF_A ? 32'(a[c]) : off == OFF_B ? 32'(b[c]) :
                    off == OFF_PL ? 32'(p[c]) : off == OFF_PH ? 32'(64'(p[c]) >> 32) :
                    off == OFF_CTRL ? 32'(ctrl[c]) : 32'd0;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        a[c] <= '0;
        b[c] <= '0;
        p[c] <= '0;
        ctrl[c] <= '0;
      end
      ovf <= '0;
      wr_drop <= 1'b0;
      prod <= '0;
      state <= S_IDLE;
      ch <= '0;
      mask <= '0;
      wb_ACK <= 1'b0;
    end else begin
      wb_ACK <= wb_CYC & wb_STB & ~wb_ACK;
      state <= nxt;
      ch <= ch_nxt;
      mask <= mask_nxt;
      if (state == S_MUL) prod <= sgn ? prod_s : prod_u;
      wr_drop <= drop | (wr_drop & ~(st_wr & wb_DAT_MOSI[ST_DROP]));
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_wr && !busy && wb_ADR[7:5] == 3'(c)) begin
          if (off == OFF_A) a[c] <= wb_DAT_MOSI[A_W-1:0];
          if (off == OFF_B) b[c] <= wb_DAT_MOSI[B_W-1:0];
          if (off == OFF_PL) p[c] <= P_W'({32'(64'(p[c]) >> 32), wb_DAT_MOSI});
          if (off == OFF_PH) p[c] <= P_W'({wb_DAT_MOSI, 32'(p[c])});
          if (off == OFF_CTRL) ctrl[c] <= wb_DAT_MOSI[2:0];
        end
        if (state == S_ACC && ch == 3'(c)) p[c] <= p_new;
        ovf[c] <= (ovf[c] & ~(st_wr & wb_DAT_MOSI[ST_OVF+c])) | (state == S_ACC && ch == 3'(c) && ov);
      end
    end
  end
  for (genvar g = 0; g < 38; g++) begin : g_io
    if (g < DAC_CH) begin : g_dac
      sd_dac_channel #(.DAC_W(DAC_W)) u_dac (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .din(la_data_in[g*DAC_W +: DAC_W]),
        .dout(io_out[g])
      );
      assign io_oeb[g] = 1'b0;
    end else begin : g_off
      assign io_out[g] = 1'b0;
      assign io_oeb[g] = 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_mac_array.sv
// tb_wb_mac_array: directed Wishbone and DAC vectors with hand-computed expectations for wb_mac_array
module tb_wb_mac_array;
  logic clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0, sel = 1'b0, ack;
  logic [31:0] adr = 32'h0, mosi = 32'h0, miso, q;
  logic [127:0] la = '0;
  logic [37:0] io_in = '0, io_out, io_oeb;
  int checks = 0, errors = 0, n, cnt, bad, last;
  always #5 clk = ~clk;
  wb_mac_array dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_CYC(cyc), .wb_STB(stb), .wb_WE(we), .wb_ACK(ack),
    .wb_ADR(adr), .wb_DAT_MOSI(mosi), .wb_DAT_MISO(miso), .wb_SEL(sel),
    .la_data_in(la), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
    int k;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; mosi = d; k = 0;
    do begin @(posedge clk); #1; k++; end while (!ack && k < 16);
    check("ack", ack, 1'b1);
    r = miso;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h104;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] t;
    wb_xfer(1'b1, a, d, t);
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'h0, r);
  endtask
  task automatic busy_cycles(output int k);
    k = 0; adr = 32'h104; #1;
    while (miso[0] && k < 64) begin k++; @(posedge clk); #1; end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ack", ack, 1'b0);
    check("rst_io_out", io_out, 38'h0);
    adr = 32'h104; #1 check("rst_status", miso, 32'h0);
    adr = 32'h008; #1 check("rst_p0", miso, 32'h0);
    check("io_oeb", io_oeb, 38'h3F_FFFF_FF00);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h104;
    check("ack_p0", ack, 1'b0);
    @(posedge clk); #1 check("ack_p1", ack, 1'b1);
    @(posedge clk); #1 check("ack_p2", ack, 1'b0);
    cyc = 1'b0; stb = 1'b0;
    // scenario 1: unsigned 3*5
    wr(32'h10, 0); wr(32'h00, 3); wr(32'h04, 5); wr(32'h08, 0); wr(32'h0C, 0);
    wr(32'h100, 1); busy_cycles(n); check("s1_busy", n, 2);
    rd(32'h08, q); check("s1_p", q, 15);
    wr(32'h100, 1); busy_cycles(n); rd(32'h08, q); check("s1_p2", q, 30);
    wr(32'h100, 0); rd(32'h104, q); check("mask0_status", q, 0);
    rd(32'h08, q); check("mask0_p", q, 30);
    // scenario 2: signed -2*7 on channel 1
    wr(32'h30, 1); wr(32'h20, 32'hFFFF_FFFE); wr(32'h24, 7); wr(32'h28, 0); wr(32'h2C, 0);
    wr(32'h100, 2); busy_cycles(n);
    rd(32'h28, q); check("s2_plo", q, 32'hFFFF_FFF2);
    rd(32'h2C, q); check("s2_phi", q, 32'h0000_FFFF);
    rd(32'h20, q); check("s2_a", q, 32'h01FF_FFFE);
    rd(32'h30, q); check("s2_ctrl", q, 1);
    // scenario 3: all four channels, with dropped writes mid-run
    wr(32'h50, 0); wr(32'h40, 2); wr(32'h44, 2); wr(32'h48, 0); wr(32'h4C, 0);
    wr(32'h70, 4); wr(32'h60, 1); wr(32'h64, 100); wr(32'h68, 1000); wr(32'h6C, 0);
    wr(32'h100, 32'hF); busy_cycles(n); check("s3_busy", n, 8);
    rd(32'h08, q); check("s3_p0", q, 45);
    rd(32'h28, q); check("s3_p1", q, 32'hFFFF_FFE4);
    rd(32'h48, q); check("s3_p2", q, 4);
    rd(32'h68, q); check("s3_p3", q, 900);
    wr(32'h100, 32'hF); wr(32'h100, 32'hF); wr(32'h00, 99);
    rd(32'h104, q); check("s3_drop", q, 2);
    rd(32'h00, q); check("s3_a_kept", q, 3);
    rd(32'h08, q); check("s3_p0b", q, 60);
    rd(32'h28, q); check("s3_p1b", q, 32'hFFFF_FFD6);
    rd(32'h48, q); check("s3_p2b", q, 8);
    rd(32'h68, q); check("s3_p3b", q, 800);
    wr(32'h104, 2); rd(32'h104, q); check("s3_clr", q, 0);
    // scenario 4: signed saturation then wrap, unsigned clamps
    wr(32'h10, 3); wr(32'h08, 32'hFFFF_FFFF); wr(32'h0C, 32'h7FFF); wr(32'h00, 1); wr(32'h04, 1);
    wr(32'h100, 1); busy_cycles(n);
    rd(32'h08, q); check("s4_sat_lo", q, 32'hFFFF_FFFF);
    rd(32'h0C, q); check("s4_sat_hi", q, 32'h7FFF);
    rd(32'h104, q); check("s4_ovf", q, 32'h100);
    wr(32'h104, 32'h100); rd(32'h104, q); check("s4_ovf_clr", q, 0);
    wr(32'h10, 1); wr(32'h08, 32'hFFFF_FFFF); wr(32'h0C, 32'h7FFF);
    wr(32'h100, 1); busy_cycles(n);
    rd(32'h08, q); check("s4_wrap_lo", q, 0);
    rd(32'h0C, q); check("s4_wrap_hi", q, 32'h8000);
    rd(32'h104, q); check("s4_ovf2", q, 32'h100);
    wr(32'h104, 32'h100);
    wr(32'h50, 2); wr(32'h48, 32'hFFFF_FFFF); wr(32'h4C, 32'hFFFF);
    wr(32'h70, 6); wr(32'h68, 1); wr(32'h6C, 0); wr(32'h64, 5);
    wr(32'h100, 32'hC); busy_cycles(n); check("s4_busy2", n, 4);
    rd(32'h48, q); check("s4_usat_lo", q, 32'hFFFF_FFFF);
    rd(32'h4C, q); check("s4_usat_hi", q, 32'hFFFF);
    rd(32'h68, q); check("s4_uzero_lo", q, 0);
    rd(32'h6C, q); check("s4_uzero_hi", q, 0);
    rd(32'h104, q); check("s4_ovf23", q, 32'hC00);
    wr(32'h104, 32'hC00);
    // unmapped space and io readback
    rd(32'h14, q); check("unmap_14", q, 0);
    rd(32'h80, q); check("unmap_80", q, 0);
    rd(32'h10C, q); check("unmap_10c", q, 0);
    wr(32'h80, 5); rd(32'h00, q); check("unmap_wr", q, 1);
    io_in = 38'h2A_DEAD_BEEF;
    rd(32'h108, q); check("io_rd", q, 32'hDEAD_BEEF);
    // scenario 5: sigma-delta density 1/4, then silence
    la[15:0] = 16'h4000;
    repeat (2) @(posedge clk);
    cnt = 0; bad = 0; last = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (io_out[0]) begin
        cnt++;
        if (last >= 0 && i - last != 4) bad++;
        last = i;
      end
    end
    check("s5_cnt", cnt, 10);
    check("s5_gap", bad, 0);
    check("s5_upper", io_out[37:8], 30'h0);
    la[15:0] = 16'h0;
    repeat (3) @(posedge clk);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (io_out[0]) cnt++; end
    check("s5_zero", cnt, 0);
    // scenario 6: reset in the ACC cycle
    wr(32'h10, 0); wr(32'h00, 3); wr(32'h04, 5); wr(32'h08, 100); wr(32'h0C, 0);
    wr(32'h100, 1);
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h08;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    check("s6_ack", ack, 1'b0);
    check("s6_p", miso, 32'h0);
    adr = 32'h104; #1 check("s6_busy", miso, 32'h0);
    @(posedge clk); #1;
    adr = 32'h08; #1 check("s6_p_next", miso, 32'h0);
    rd(32'h00, q); check("s6_a", q, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
